// File: rtl/mc_controller.sv
// mc_controller: multi-cycle instruction controller, a Moore FSM.
//   IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WAIT* -> WB -> FETCH, or HALT.
// Each instruction retires in exactly one cycle. Buff_PC is high in that
// cycle, and instr_cnt (saturating) counts the retired instructions.
//
// Parameters:
//   OPC_W   opcode width. Defined opcodes use the low 5 bits and the upper bits must be 0.
//   MEM_LAT extra WAIT cycles after MEM for loads/stores (0..7).
//   CNT_W   width of the retired-instruction counter.
// Optional feature (macro CTRL_STEP_EN):
//   Adds the input `step`. FETCH stalls until a cycle with step=1.
// Ports:
//   clk, Rst (async, active-high), start (leave IDLE)
//   opcode, ALUopcode, PSW_NZC ({N,Z,C})  decode inputs
//   Buff_MEMIns, MEMresource, WE_MEM, ALUorNot, LIorMOV   memory-stage controls
//   WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF register-file controls
//   Flag, ALUop, Buff_PSW                                 ALU controls
//   Jump[1:0], Branch, Buff_PC                            PC controls
//   done (halted), illegal (undefined-opcode pulse), instr_cnt
module mc_controller #(
    parameter int OPC_W   = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             start,
`ifdef CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic [OPC_W-1:0] opcode,
    input  logic [1:0]       ALUopcode,
    input  logic [2:0]       PSW_NZC,
    output logic             Buff_MEMIns,
    output logic             MEMresource,
    output logic             WE_MEM,
    output logic             ALUorNot,
    output logic             LIorMOV,
    output logic             WBresource,
    output logic             RBresource,
    output logic             oprandB,
    output logic             LI,
    output logic             PCplus1orWB,
    output logic             WE_RF,
    output logic             Flag,
    output logic             ALUop,
    output logic             Buff_PSW,
    output logic [1:0]       Jump,
    output logic             Branch,
    output logic             Buff_PC,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WAIT, S_WB, S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_LLI   = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_LHI   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_LDRRI = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_LDRRR = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_STRRI = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_STRRR = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_ALU   = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] OP_OUTR  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_BCC   = OPC_W'(5'b01001);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(5'b01010);
    localparam logic [OPC_W-1:0] OP_HLT   = OPC_W'(5'b11111);

    // Value of the WAIT counter in the last WAIT cycle.
    localparam logic [2:0] LAT_LAST = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

    state_t             state_reg, state_next;
    logic [OPC_W-1:0]   opc_reg;
    logic [1:0]         aluop_reg;
    logic [2:0]         wait_cnt_reg;
    logic [CNT_W-1:0]   instr_cnt_reg;
    logic               retire;
    logic               fetch_go;

    // Instruction class, decoded only from the latched opcode.
    logic i_lli, i_lhi, i_ldr, i_str, i_alu, i_outr, i_bcc, i_jmp, i_hlt, i_imm, i_bad;
    logic cond_true;

`ifdef CTRL_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        {i_lli, i_lhi, i_ldr, i_str, i_alu, i_outr, i_bcc, i_jmp, i_hlt, i_imm, i_bad} = '0;
        case (opc_reg)
            OP_LLI:   i_lli  = 1'b1;
            OP_LHI:   i_lhi  = 1'b1;
            OP_LDRRI: begin i_ldr = 1'b1; i_imm = 1'b1; end
            OP_LDRRR: i_ldr  = 1'b1;
            OP_STRRI: begin i_str = 1'b1; i_imm = 1'b1; end
            OP_STRRR: i_str  = 1'b1;
            OP_ALU:   i_alu  = 1'b1;
            OP_OUTR:  i_outr = 1'b1;
            OP_BCC:   i_bcc  = 1'b1;
            OP_JMP:   i_jmp  = 1'b1;
            OP_HLT:   i_hlt  = 1'b1;
            default:  i_bad  = 1'b1;
        endcase
    end

    // Branch condition: 00 always, 01 Z, 10 C, 11 N.
    always_comb begin
        case (aluop_reg)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = PSW_NZC[1];
            2'b10:   cond_true = PSW_NZC[0];
            default: cond_true = PSW_NZC[2];
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        retire      = 1'b0;
        Buff_MEMIns = 1'b0;
        MEMresource = 1'b0;
        WE_MEM      = 1'b0;
        ALUorNot    = 1'b0;
        LIorMOV     = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        oprandB     = 1'b0;
        LI          = 1'b0;
        PCplus1orWB = 1'b0;
        WE_RF       = 1'b0;
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Buff_PSW    = 1'b0;
        Jump        = 2'b00;
        Branch      = 1'b0;
        Buff_PC     = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_go) begin
                    Buff_MEMIns = 1'b1;
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (i_hlt) begin
                    state_next = S_HALT;
                end else if (i_outr || i_bcc || i_jmp || i_bad) begin
                    // Single-cycle instructions (and NOPs for bad opcodes) retire here.
                    retire     = 1'b1;
                    Buff_PC    = 1'b1;
                    Branch     = i_bcc & cond_true;
                    Jump       = i_jmp ? 2'b01 : 2'b00;
                    illegal    = i_bad;
                    state_next = S_FETCH;
                end else begin
                    oprandB    = (i_ldr | i_str) & i_imm;
                    RBresource = i_lhi;
                    LI         = i_lhi;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                Buff_PSW   = i_ldr | i_str | i_alu;
                RBresource = i_str;
                ALUop      = i_alu & aluop_reg[1];
                Flag       = i_alu & aluop_reg[0];
                state_next = S_MEM;
            end
            S_MEM: begin
                ALUorNot    = i_lli | i_lhi;
                MEMresource = i_ldr | i_str;
                WE_MEM      = i_str;
                if ((i_ldr || i_str) && MEM_LAT != 0) begin
                    state_next = S_WAIT;
                end else if (i_str) begin
                    retire     = 1'b1;
                    Buff_PC    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WAIT: begin
                MEMresource = 1'b1;
                if (wait_cnt_reg == LAT_LAST) begin
                    if (i_str) begin
                        retire     = 1'b1;
                        Buff_PC    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                WE_RF       = 1'b1;
                PCplus1orWB = 1'b1;
                WBresource  = i_ldr;
                Buff_PC     = 1'b1;
                retire      = 1'b1;
                state_next  = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_reg     <= S_IDLE;
            opc_reg       <= '0;
            aluop_reg     <= '0;
            wait_cnt_reg  <= '0;
            instr_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH && fetch_go) begin
                opc_reg   <= opcode;
                aluop_reg <= ALUopcode;
            end
            if (state_reg == S_MEM)
                wait_cnt_reg <= '0;
            else if (state_reg == S_WAIT)
                wait_cnt_reg <= wait_cnt_reg + 3'd1;
            if (retire && instr_cnt_reg != '1)
                instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end
    end

    assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller. It uses three instances: the default one,
// one with MEM_LAT=3 and one with CNT_W=2. The instances share their inputs.
// Each instance has its own reset, so the instances that are not under test
// are parked in reset. The control outputs of an instance are packed into a
// 20-bit vector. In every cycle that vector is compared with a hand-written
// expected pattern.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_m, rst_l, rst_c;
    logic       start;
    logic [4:0] opcode;
    logic [1:0] alu_in;
    logic [2:0] psw;
    int         sel;

    always #5 clk = ~clk;

    // Packed control vector, bit order:
    // 19 Buff_MEMIns 18 MEMresource 17 WE_MEM 16 ALUorNot 15 LIorMOV 14 WBresource
    // 13 RBresource 12 oprandB 11 LI 10 PCplus1orWB 9 WE_RF 8 Flag 7 ALUop 6 Buff_PSW
    // 5:4 Jump 3 Branch 2 Buff_PC 1 done 0 illegal
    localparam logic [19:0] M_MEMINS = 20'd1 << 19;
    localparam logic [19:0] M_MEMRES = 20'd1 << 18;
    localparam logic [19:0] M_WEMEM  = 20'd1 << 17;
    localparam logic [19:0] M_ALUOR  = 20'd1 << 16;
    localparam logic [19:0] M_WBRES  = 20'd1 << 14;
    localparam logic [19:0] M_RB     = 20'd1 << 13;
    localparam logic [19:0] M_OPB    = 20'd1 << 12;
    localparam logic [19:0] M_LI     = 20'd1 << 11;
    localparam logic [19:0] M_PC1    = 20'd1 << 10;
    localparam logic [19:0] M_WERF   = 20'd1 << 9;
    localparam logic [19:0] M_FLAG   = 20'd1 << 8;
    localparam logic [19:0] M_ALUOP  = 20'd1 << 7;
    localparam logic [19:0] M_PSW    = 20'd1 << 6;
    localparam logic [19:0] M_JMP01  = 20'd1 << 4;
    localparam logic [19:0] M_BR     = 20'd1 << 3;
    localparam logic [19:0] M_BPC    = 20'd1 << 2;
    localparam logic [19:0] M_DONE   = 20'd1 << 1;
    localparam logic [19:0] M_ILL    = 20'd1;
    localparam logic [19:0] M_WB     = M_WERF | M_PC1 | M_BPC;

    logic [19:0] ctrl_m, ctrl_l, ctrl_c, ctrl_cur;
    logic [15:0] cnt_m, cnt_l, cnt_cur;
    logic [1:0]  cnt_c;

    // Per-instance output wires.
    logic m_memins, m_memres, m_wemem, m_aluor, m_limov, m_wbres, m_rb, m_opb, m_li, m_pc1, m_werf;
    logic m_flag, m_aluop, m_psw, m_br, m_bpc, m_done, m_ill;
    logic [1:0] m_jump;
    logic l_memins, l_memres, l_wemem, l_aluor, l_limov, l_wbres, l_rb, l_opb, l_li, l_pc1, l_werf;
    logic l_flag, l_aluop, l_psw, l_br, l_bpc, l_done, l_ill;
    logic [1:0] l_jump;
    logic c_memins, c_memres, c_wemem, c_aluor, c_limov, c_wbres, c_rb, c_opb, c_li, c_pc1, c_werf;
    logic c_flag, c_aluop, c_psw, c_br, c_bpc, c_done, c_ill;
    logic [1:0] c_jump;

    assign ctrl_m = {m_memins, m_memres, m_wemem, m_aluor, m_limov, m_wbres, m_rb, m_opb, m_li,
                     m_pc1, m_werf, m_flag, m_aluop, m_psw, m_jump, m_br, m_bpc, m_done, m_ill};
    assign ctrl_l = {l_memins, l_memres, l_wemem, l_aluor, l_limov, l_wbres, l_rb, l_opb, l_li,
                     l_pc1, l_werf, l_flag, l_aluop, l_psw, l_jump, l_br, l_bpc, l_done, l_ill};
    assign ctrl_c = {c_memins, c_memres, c_wemem, c_aluor, c_limov, c_wbres, c_rb, c_opb, c_li,
                     c_pc1, c_werf, c_flag, c_aluop, c_psw, c_jump, c_br, c_bpc, c_done, c_ill};
    assign ctrl_cur = (sel == 2) ? ctrl_c : (sel == 1) ? ctrl_l : ctrl_m;
    assign cnt_cur  = (sel == 2) ? 16'(cnt_c) : (sel == 1) ? cnt_l : cnt_m;

    mc_controller dut_m (
        .clk(clk), .Rst(rst_m), .start(start),
`ifdef CTRL_STEP_EN
        .step(1'b1),
`endif
        .opcode(opcode), .ALUopcode(alu_in), .PSW_NZC(psw),
        .Buff_MEMIns(m_memins), .MEMresource(m_memres), .WE_MEM(m_wemem), .ALUorNot(m_aluor),
        .LIorMOV(m_limov), .WBresource(m_wbres), .RBresource(m_rb), .oprandB(m_opb), .LI(m_li),
        .PCplus1orWB(m_pc1), .WE_RF(m_werf), .Flag(m_flag), .ALUop(m_aluop), .Buff_PSW(m_psw),
        .Jump(m_jump), .Branch(m_br), .Buff_PC(m_bpc), .done(m_done), .illegal(m_ill),
        .instr_cnt(cnt_m)
    );

    mc_controller #(.MEM_LAT(3)) dut_l (
        .clk(clk), .Rst(rst_l), .start(start),
`ifdef CTRL_STEP_EN
        .step(1'b1),
`endif
        .opcode(opcode), .ALUopcode(alu_in), .PSW_NZC(psw),
        .Buff_MEMIns(l_memins), .MEMresource(l_memres), .WE_MEM(l_wemem), .ALUorNot(l_aluor),
        .LIorMOV(l_limov), .WBresource(l_wbres), .RBresource(l_rb), .oprandB(l_opb), .LI(l_li),
        .PCplus1orWB(l_pc1), .WE_RF(l_werf), .Flag(l_flag), .ALUop(l_aluop), .Buff_PSW(l_psw),
        .Jump(l_jump), .Branch(l_br), .Buff_PC(l_bpc), .done(l_done), .illegal(l_ill),
        .instr_cnt(cnt_l)
    );

    mc_controller #(.CNT_W(2)) dut_c (
        .clk(clk), .Rst(rst_c), .start(start),
`ifdef CTRL_STEP_EN
        .step(1'b1),
`endif
        .opcode(opcode), .ALUopcode(alu_in), .PSW_NZC(psw),
        .Buff_MEMIns(c_memins), .MEMresource(c_memres), .WE_MEM(c_wemem), .ALUorNot(c_aluor),
        .LIorMOV(c_limov), .WBresource(c_wbres), .RBresource(c_rb), .oprandB(c_opb), .LI(c_li),
        .PCplus1orWB(c_pc1), .WE_RF(c_werf), .Flag(c_flag), .ALUop(c_aluop), .Buff_PSW(c_psw),
        .Jump(c_jump), .Branch(c_br), .Buff_PC(c_bpc), .done(c_done), .illegal(c_ill),
        .instr_cnt(cnt_c)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Runs one instruction on the selected instance. The first negedge must
    // fall in its FETCH cycle, and the cycles follow exp_q in order. After the
    // latch, the opcode and ALUopcode inputs are scrambled. This proves that
    // DECODE works from the latched copy.
    task automatic run(input string tag, input logic [4:0] op, input logic [1:0] alu,
                       input int cnt_exp);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s.c%0d", tag, i), 32'(ctrl_cur), 32'(exp_q[i]));
            if (i == 0) begin
                check({tag, ".cnt"}, 32'(cnt_cur), 32'(cnt_exp));
                start  = 1'b0;
                opcode = op;
                alu_in = alu;
            end else begin
                opcode = 5'b11111;
                alu_in = ~alu;
            end
        end
        $display("%-10s op=%b alu=%b psw=%b cycles=%0d cnt_before=%0d", tag, op, alu, psw,
                 exp_q.size(), cnt_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst_m = 1'b1; rst_l = 1'b1; rst_c = 1'b1;
        start = 1'b0; opcode = '0; alu_in = '0; psw = '0; sel = 0;

        // Reset state of all instances, with start ignored while in reset.
        start = 1'b1;
        @(negedge clk);
        check("rst.ctrl_m", 32'(ctrl_m), 32'd0);
        check("rst.cnt_m", 32'(cnt_m), 32'd0);
        check("rst.ctrl_l", 32'(ctrl_l), 32'd0);
        check("rst.ctrl_c", 32'(ctrl_c), 32'd0);
        start = 1'b0;

        // IDLE holds until start.
        rst_m = 1'b0;
        @(negedge clk); check("idle0", 32'(ctrl_m), 32'd0);
        @(negedge clk); check("idle1", 32'(ctrl_m), 32'd0);
        start = 1'b1;

        exp_q = '{M_MEMINS, 20'd0, 20'd0, M_ALUOR, M_WB};
        run("LLI", 5'b00001, 2'b00, 0);
        exp_q = '{M_MEMINS, M_RB | M_LI, 20'd0, M_ALUOR, M_WB};
        run("LHI", 5'b00010, 2'b00, 1);
        exp_q = '{M_MEMINS, 20'd0, M_PSW | M_FLAG | M_ALUOP, 20'd0, M_WB};
        run("ALU_SBB", 5'b00111, 2'b11, 2);
        exp_q = '{M_MEMINS, 20'd0, M_PSW | M_ALUOP, 20'd0, M_WB};
        run("ALU_SUB", 5'b00111, 2'b10, 3);
        exp_q = '{M_MEMINS, M_OPB, M_PSW, M_MEMRES, M_WB | M_WBRES};
        run("LDRri", 5'b00011, 2'b00, 4);
        exp_q = '{M_MEMINS, M_OPB, M_PSW | M_RB, M_MEMRES | M_WEMEM | M_BPC};
        run("STRri", 5'b00101, 2'b00, 5);
        exp_q = '{M_MEMINS, 20'd0, M_PSW | M_RB, M_MEMRES | M_WEMEM | M_BPC};
        run("STRrr", 5'b00110, 2'b00, 6);
        exp_q = '{M_MEMINS, M_BPC};
        run("OUTR", 5'b01000, 2'b00, 7);
        psw = 3'b010;
        exp_q = '{M_MEMINS, M_BR | M_BPC};
        run("BCC_Z_t", 5'b01001, 2'b01, 8);
        psw = 3'b000;
        exp_q = '{M_MEMINS, M_BPC};
        run("BCC_Z_f", 5'b01001, 2'b01, 9);
        exp_q = '{M_MEMINS, M_BR | M_BPC};
        run("BCC_AL", 5'b01001, 2'b00, 10);
        psw = 3'b001;
        run("BCC_C_t", 5'b01001, 2'b10, 11);
        psw = 3'b100;
        run("BCC_N_t", 5'b01001, 2'b11, 12);
        psw = 3'b000;
        exp_q = '{M_MEMINS, M_JMP01 | M_BPC};
        run("JMP", 5'b01010, 2'b00, 13);
        exp_q = '{M_MEMINS, M_ILL | M_BPC};
        run("ILLEGAL", 5'b01111, 2'b00, 14);
        exp_q = '{M_MEMINS, 20'd0};
        run("HLT", 5'b11111, 2'b00, 15);

        // HALT holds done, ignores start, and the count does not move.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b1;
            check($sformatf("halt%0d", i), 32'(ctrl_m), 32'(M_DONE));
            check($sformatf("halt_cnt%0d", i), 32'(cnt_m), 32'd15);
        end
        start = 1'b0;

        // Asynchronous reset in the middle of the MEM cycle of STRri.
        rst_m = 1'b1;
        @(negedge clk);
        rst_m = 1'b0;
        start = 1'b1;
        exp_q = '{M_MEMINS, M_OPB, M_PSW | M_RB, M_MEMRES | M_WEMEM | M_BPC};
        run("STR_RST", 5'b00101, 2'b00, 0);
        rst_m = 1'b1;
        #1;
        check("rst_mid.ctrl", 32'(ctrl_m), 32'd0);
        check("rst_mid.cnt", 32'(cnt_m), 32'd0);
        rst_m = 1'b0;
        @(negedge clk);
        check("rst_mid.idle", 32'(ctrl_m), 32'd0);
        rst_m = 1'b1;

        // MEM_LAT = 3 instance.
        sel = 1;
        rst_l = 1'b0;
        start = 1'b1;
        exp_q = '{M_MEMINS, 20'd0, M_PSW, M_MEMRES, M_MEMRES, M_MEMRES, M_MEMRES, M_WB | M_WBRES};
        run("L3_LDRrr", 5'b00100, 2'b00, 0);
        exp_q = '{M_MEMINS, M_OPB, M_PSW | M_RB, M_MEMRES | M_WEMEM, M_MEMRES, M_MEMRES,
                  M_MEMRES | M_BPC};
        run("L3_STRri", 5'b00101, 2'b00, 1);
        exp_q = '{M_MEMINS, 20'd0, 20'd0, M_ALUOR, M_WB};
        run("L3_LLI", 5'b00001, 2'b00, 2);
        @(negedge clk);
        check("L3.fetch", 32'(ctrl_l), 32'(M_MEMINS));
        check("L3.cnt", 32'(cnt_l), 32'd3);
        rst_l = 1'b1;

        // CNT_W = 2 instance: the count saturates at 3.
        sel = 2;
        rst_c = 1'b0;
        start = 1'b1;
        exp_q = '{M_MEMINS, M_BPC};
        for (int k = 0; k < 5; k++)
            run($sformatf("C2_OUTR%0d", k), 5'b01000, 2'b00, (k > 3) ? 3 : k);
        @(negedge clk);
        check("C2.fetch", 32'(ctrl_c), 32'(M_MEMINS));
        check("C2.cnt_sat", 32'(cnt_c), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
